rf_wr_arbiter: RTL and testbench
================================

Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port among NREQ requesters, e.g. ALU writeback, load unit and debug port.
- Uses round-robin arbitration with a req/gnt handshake.
- A `lock` input lets a requester hold the port for a bounded burst of consecutive writes.
- Sits between the execution units and the register file, which is built from the team's dff cells. All write-port outputs are registered.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 4, register address width (16 registers)
- DATA_W, 16, register data width
- MAX_BURST, 4, maximum consecutive grants to one locked requester (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- req  in  NREQ  per-requester write request
- lock  in  NREQ  per-requester burst hold; meaningful only while that requester is granted
- wr_addr  in  NREQ*ADDR_W  flattened addresses; requester k uses bits [k*ADDR_W +: ADDR_W]
- wr_data  in  NREQ*DATA_W  flattened data; requester k uses bits [k*DATA_W +: DATA_W]
- gnt  out  NREQ  one-hot grant; high for the cycle in which the requester's write is presented
- rf_we  out  1  register-file write enable
- rf_addr  out  ADDR_W  register-file write address
- rf_data  out  DATA_W  register-file write data
- busy  out  1  equals |gnt

Behaviour:
- **Reset** (rst=0, asynchronous): gnt=0, rf_we=0, rf_addr=0, rf_data=0, ptr=0, burst_cnt=0, state=IDLE.
- **States:**
  - IDLE: no grant.
  - GRANT: exactly one gnt bit set.
- **Arbitration** runs at every rising edge where state=IDLE, or state=GRANT and the burst is not continuing.
  - Winner k = first asserted req bit scanning ptr, ptr+1, ... NREQ-1, 0, ... (mod NREQ).
  - Registered at that edge: gnt <= onehot(k), rf_we <= 1, rf_addr <= wr_addr[k], rf_data <= wr_data[k], ptr <= (k+1) mod NREQ, burst_cnt <= 1, state <= GRANT.
  - If no req is asserted: gnt <= 0, rf_we <= 0, state <= IDLE. rf_addr/rf_data hold their last values.
- **Latency:** gnt and the write appear one cycle after req is sampled high. The register file commits at the following edge.
- **Handshake:**
  - A requester holds req, wr_addr and wr_data stable until it observes its gnt bit high.
  - Its data is captured on the edge that raises gnt.
  - It must deassert req during the gnt cycle, or the still-high req is sampled as a new request.
- **Burst continuation:** at an edge with gnt[k]=1, the burst continues if req[k]=1, lock[k]=1 and burst_cnt < MAX_BURST. Then:
  - gnt is unchanged and rf_we stays 1.
  - rf_addr/rf_data reload from requester k.
  - burst_cnt increments; ptr is unchanged (already k+1).
- **Burst cap:** when burst_cnt = MAX_BURST, re-arbitration is forced. Because ptr = k+1, k is considered last. If no other requester is pending, k is re-granted with burst_cnt=1.
- **Back-to-back grants** carry no bubble: GRANT to GRANT with a different winner in consecutive cycles.
- **lock** on a requester that is not granted is ignored.
- **Reset mid-burst** aborts immediately: rf_we drops asynchronously and no partial state is kept.
- **req dropped while granted:** the burst ends, and arbitration for the next edge excludes the dropped requester.

Test Plan:
- **Reset:** hold rst=0 with req=4'b1111 -> gnt=0, rf_we=0, rf_addr=0, rf_data=0 throughout. Release rst -> first gnt=4'b0001 one cycle later.
- **Round-robin fairness:** req=4'b1111 held with no lock, data k = 16'h00A0+k -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, rf_data tracks 00A0..00A3, no idle cycles.
- **Single requester:** req[2] pulsed one cycle, wr_addr[2]=4'h7, wr_data[2]=16'hBEEF -> next cycle gnt=0100, rf_we=1, rf_addr=7, rf_data=BEEF. The cycle after -> gnt=0, rf_we=0, busy=0.
- **Locked burst with cap:**
  - req=4'b0011, lock[0]=1, MAX_BURST=4 -> gnt[0] for 4 consecutive cycles with fresh data each cycle, then gnt[1] for one cycle, then gnt[0] again.
  - Repeat with req[1]=0 -> gnt[0] continuous, burst_cnt wraps 4 to 1.
- **Lock without grant:** lock[3]=1 while requester 1 is granted -> no effect; order unchanged.
- **Asynchronous reset mid-burst:** rst pulsed low between clock edges during gnt[0] -> gnt and rf_we drop immediately, not at the next edge. After release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-port bundle shared by the requesters and the arbiter.
// The master side drives requests and per-requester write payloads. The slave
// side (the arbiter) returns the one-hot grant and the registered write port.
interface rf_wr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ*ADDR_W-1:0] wr_addr;
  logic [NREQ*DATA_W-1:0] wr_data;
  logic [NREQ-1:0]        gnt;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_addr;
  logic [DATA_W-1:0]      rf_data;
  logic                   busy;

  modport master (
    output req, lock, wr_addr, wr_data,
    input  gnt, rf_we, rf_addr, rf_data, busy
  );

  modport slave (
    input  req, lock, wr_addr, wr_data,
    output gnt, rf_we, rf_addr, rf_data, busy
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// A granted requester that holds lock keeps the port for up to MAX_BURST
// consecutive writes. After that it is forced back into arbitration with the
// lowest priority. Every write-port output comes straight from a flop.
module rf_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_wr_arbiter_if.slave    bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_nextPtr;
  logic [CNT_W-1:0]  r_burstCnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   w_nextGnt;
  logic              r_we;
  logic              w_nextWe;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_nextAddr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_nextData;

  logic [ADDR_W-1:0] w_addrArr [NREQ];
  logic [DATA_W-1:0] w_dataArr [NREQ];
  logic              w_found;
  logic [PTR_W-1:0]  w_winner;
  logic [PTR_W-1:0]  w_ownerIdx;
  logic              w_continue;

  // Split the flattened payload buses into one address/data entry per requester
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      w_addrArr[k] = bus.wr_addr[k*ADDR_W +: ADDR_W];
      w_dataArr[k] = bus.wr_data[k*DATA_W +: DATA_W];
    end
  end

  // Round-robin search: lowest request at or above ptr wins, otherwise lowest below ptr
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k] && (k < int'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(k);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k] && (k >= int'(r_ptr))) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(k);
      end
    end
  end

  // Encode the index of the requester that currently owns the port
  always_comb begin
    w_ownerIdx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_gnt[k]) w_ownerIdx = PTR_W'(k);
    end
  end

  // A burst continues only for the granted requester, and only while it still requests, locks and has budget left
  assign w_continue = (r_state == GRANT) && (|(r_gnt & bus.req & bus.lock)) &&
                      (r_burstCnt < CNT_MAX);

  // State register: the FSM returns to IDLE as soon as reset asserts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Next state: stay granted while a burst continues or any requester is pending
  always_comb begin
    w_nextState = IDLE;
    if (w_continue || w_found) w_nextState = GRANT;
  end

  // Next write-port values: reload the owner on a burst, load a new winner, or go idle holding address/data
  always_comb begin
    w_nextGnt  = r_gnt;
    w_nextWe   = r_we;
    w_nextAddr = r_addr;
    w_nextData = r_data;
    w_nextPtr  = r_ptr;
    w_nextCnt  = r_burstCnt;
    if (w_continue) begin
      w_nextAddr = w_addrArr[w_ownerIdx];
      w_nextData = w_dataArr[w_ownerIdx];
      w_nextCnt  = r_burstCnt + CNT_W'(1);
    end else if (w_found) begin
      w_nextGnt  = NREQ'(1) << w_winner;
      w_nextWe   = 1'b1;
      w_nextAddr = w_addrArr[w_winner];
      w_nextData = w_dataArr[w_winner];
      w_nextPtr  = (w_winner == PTR_LAST) ? '0 : w_winner + PTR_W'(1);
      w_nextCnt  = CNT_W'(1);
    end else begin
      w_nextGnt = '0;
      w_nextWe  = 1'b0;
    end
  end

  // Write-port and arbitration registers; reset drops the write enable immediately mid-burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_ptr      <= '0;
      r_burstCnt <= '0;
    end else begin
      r_gnt      <= w_nextGnt;
      r_we       <= w_nextWe;
      r_addr     <= w_nextAddr;
      r_data     <= w_nextData;
      r_ptr      <= w_nextPtr;
      r_burstCnt <= w_nextCnt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.rf_we   = r_we;
  assign bus.rf_addr = r_addr;
  assign bus.rf_data = r_data;
  assign bus.busy    = |r_gnt;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboard bench for rf_wr_arbiter (NREQ=4, ADDR_W=4, DATA_W=16, MAX_BURST=4).
// Stimulus pushes hand-computed writes tagged with the cycle in which they must
// appear. A monitor pops one entry for each write the arbiter presents.
module tb_rf_wr_arbiter;

  typedef struct {
    int          cyc;
    logic [3:0]  gnt;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nVectors = 0;
  int   nMiscompares = 0;
  exp_t sbQ[$];
  exp_t monE;

  rf_wr_arbiter_if #(.NREQ(4), .ADDR_W(4), .DATA_W(16)) bus ();

  rf_wr_arbiter #(.NREQ(4), .ADDR_W(4), .DATA_W(16), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock with rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp the expected writes
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each presented write must match the oldest expected write, including its cycle
  always @(negedge clk) begin
    if (rst && bus.rf_we) begin
      nVectors++;
      if (sbQ.size() == 0) begin
        nMiscompares++;
        $display("[TB] FAIL unexpectedWrite: cyc=%0d gnt=%b addr=%h data=%h, expected no write",
                 cyc, bus.gnt, bus.rf_addr, bus.rf_data);
      end else begin
        monE = sbQ.pop_front();
        if (cyc != monE.cyc || bus.gnt !== monE.gnt || bus.rf_addr !== monE.addr ||
            bus.rf_data !== monE.data || bus.busy !== 1'b1) begin
          nMiscompares++;
          $display("[TB] FAIL write: got cyc=%0d gnt=%b addr=%h data=%h busy=%b, expected cyc=%0d gnt=%b addr=%h data=%h busy=1",
                   cyc, bus.gnt, bus.rf_addr, bus.rf_data, bus.busy,
                   monE.cyc, monE.gnt, monE.addr, monE.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSlot(input int k, input logic [3:0] a, input logic [15:0] d);
    bus.wr_addr[k*4 +: 4]   = a;
    bus.wr_data[k*16 +: 16] = d;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l);
    bus.req  = r;
    bus.lock = l;
  endtask

  task automatic expectWrite(input logic [3:0] g, input logic [3:0] a, input logic [15:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.gnt  = g;
    e.addr = a;
    e.data = d;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g, input logic we,
                             input logic [3:0] a, input logic [15:0] d, input logic b);
    nVectors++;
    if (bus.gnt !== g || bus.rf_we !== we || bus.rf_addr !== a ||
        bus.rf_data !== d || bus.busy !== b) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got gnt=%b we=%b addr=%h data=%h busy=%b, expected gnt=%b we=%b addr=%h data=%h busy=%b",
               name, bus.gnt, bus.rf_we, bus.rf_addr, bus.rf_data, bus.busy, g, we, a, d, b);
    end
  endtask

  initial begin
    // Reset held with every requester asserting: nothing may be granted
    rst = 1'b0;
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 4; k++) setSlot(k, 4'(8 + k), 16'h00A0 + 16'(k));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("resetHold", 4'b0000, 1'b0, 4'h0, 16'h0000, 1'b0);
    end

    // Release: round robin from requester 0 with no bubbles
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expectWrite(4'(1 << (i % 4)), 4'(8 + (i % 4)), 16'h00A0 + 16'(i % 4));
      tick();
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("rrIdle", 4'b0000, 1'b0, 4'h8, 16'h00A0, 1'b0);

    // Single one-cycle request from requester 2
    setSlot(2, 4'h7, 16'hBEEF);
    applyStimulus(4'b0100, 4'b0000);
    expectWrite(4'b0100, 4'h7, 16'hBEEF);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("singleIdle", 4'b0000, 1'b0, 4'h7, 16'hBEEF, 1'b0);

    // Locked burst of four from requester 0, forced hand-over to 1, then back to 0
    setSlot(1, 4'hF, 16'hD001);
    applyStimulus(4'b0011, 4'b0001);
    for (int n = 1; n <= 6; n++) begin
      setSlot(0, 4'(n), 16'hC000 + 16'(n));
      if (n == 5) expectWrite(4'b0010, 4'hF, 16'hD001);
      else        expectWrite(4'b0001, 4'(n), 16'hC000 + 16'(n));
      tick();
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("capIdle", 4'b0000, 1'b0, 4'h6, 16'hC006, 1'b0);

    // Lone locked requester is re-granted after the cap with a fresh count; a late requester waits for the next cap
    applyStimulus(4'b0001, 4'b0001);
    for (int n = 1; n <= 9; n++) begin
      if (n <= 8) setSlot(0, 4'(n), 16'hE000 + 16'(n));
      if (n == 7) begin
        setSlot(1, 4'hF, 16'hD009);
        applyStimulus(4'b0011, 4'b0001);
      end
      if (n == 9) expectWrite(4'b0010, 4'hF, 16'hD009);
      else        expectWrite(4'b0001, 4'(n), 16'hE000 + 16'(n));
      tick();
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("wrapIdle", 4'b0000, 1'b0, 4'hF, 16'hD009, 1'b0);

    // lock on an ungranted requester must not stretch requester 1's grant
    setSlot(1, 4'h9, 16'h1111);
    setSlot(2, 4'hA, 16'h2222);
    applyStimulus(4'b0110, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expectWrite(4'b0100, 4'hA, 16'h2222);
      else            expectWrite(4'b0010, 4'h9, 16'h1111);
      tick();
    end
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("lockIdle", 4'b0000, 1'b0, 4'h9, 16'h1111, 1'b0);

    // Reset between edges mid-burst drops the port at once and restarts arbitration at requester 0
    setSlot(0, 4'h5, 16'h5555);
    applyStimulus(4'b0001, 4'b0001);
    expectWrite(4'b0001, 4'h5, 16'h5555);
    tick();
    setSlot(0, 4'h6, 16'h6666);
    tick();
    checkOutput("burstCont", 4'b0001, 1'b1, 4'h6, 16'h6666, 1'b1);
    #2 rst = 1'b0;
    #1 checkOutput("asyncDrop", 4'b0000, 1'b0, 4'h0, 16'h0000, 1'b0);
    setSlot(1, 4'h3, 16'h3333);
    applyStimulus(4'b0011, 4'b0000);
    tick();
    checkOutput("resetArb", 4'b0000, 1'b0, 4'h0, 16'h0000, 1'b0);
    rst = 1'b1;
    expectWrite(4'b0001, 4'h6, 16'h6666);
    tick();
    expectWrite(4'b0010, 4'h3, 16'h3333);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("finalIdle", 4'b0000, 1'b0, 4'h3, 16'h3333, 1'b0);

    // Every expected write must have been consumed within a bounded number of cycles
    for (int i = 0; i < 20 && sbQ.size() != 0; i++) tick();
    nVectors++;
    if (sbQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL scoreboardDrain: %0d writes still pending, expected 0", sbQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
